// File: rtl/mul_pkg.sv
// Shared types and defaults for the radix-16 Booth multiplier slice.
// The controller state enum lives here so the bench and sub-modules agree on encodings.
package mul_pkg;

  localparam int WIDTH = 32;
  localparam bit FpuMultiplier = 1'b0;

  localparam int MulIters = WIDTH / 4;
  localparam int MulCntWidth = $clog2(MulIters) + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CAPTURE,
    VALID
  } mul_ctrl_state_t;

endpackage

// File: rtl/mul_ctrl_if.sv
// Issue/consume handshake bus between the issuing unit and mul_ctrl.
// The master side is the issuing unit; the slave side is the controller.
interface mul_ctrl_if
  import mul_pkg::*;
#(
  parameter int WIDTH = mul_pkg::WIDTH
) ();

  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [WIDTH-1:0]       multiplicand_i;
  logic [WIDTH-1:0]       multiplier_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [2*WIDTH-1:0]     product_o;
  logic [WIDTH-1:0]       product_rounded_o;

  modport master (
    output in_valid_i,
    output multiplicand_i,
    output multiplier_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  product_o,
    input  product_rounded_o
  );

  modport slave (
    input  in_valid_i,
    input  multiplicand_i,
    input  multiplier_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output product_o,
    output product_rounded_o
  );

endinterface

// File: rtl/mul_ctrl_fsm.sv
// Sequencing FSM for mul_ctrl: state, iteration counter and handshake decode.
// Emits single-cycle strobes that tell the top when to load operands/results.
module mul_ctrl_fsm
  import mul_pkg::*;
#(
  parameter int WIDTH    = mul_pkg::WIDTH,
  parameter bit ZeroSkip = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic out_ready,
  input  logic operand_zero,
  output logic in_ready,
  output logic accept,
  output logic zero_load,
  output logic dp_start,
  output logic capture,
  output logic out_valid,
  output logic done,
  output logic busy
);

  localparam int Iters    = WIDTH / 4;
  localparam int CntWidth = $clog2(Iters) + 1;

  mul_ctrl_state_t state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A new pair may be taken from IDLE, or from VALID in the same cycle the result leaves.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    accept    = 1'b0;
    zero_load = 1'b0;
    dp_start  = 1'b0;
    capture   = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          if (ZeroSkip && operand_zero) begin
            zero_load = 1'b1;
            state_d   = VALID;
          end else begin
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        dp_start = 1'b1;
        cnt_d    = CntWidth'(Iters - 1);
        state_d  = RUN;
      end

      RUN: begin
        if (cnt_q == '0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end

      CAPTURE: begin
        capture = 1'b1;
        state_d = VALID;
      end

      VALID: begin
        out_valid = 1'b1;
        if (out_ready) begin
          done     = 1'b1;
          in_ready = 1'b1;
          if (in_valid) begin
            accept = 1'b1;
            if (ZeroSkip && operand_zero) begin
              zero_load = 1'b1;
              state_d   = VALID;
            end else begin
              state_d = LOAD;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: rtl/mul_ctrl.sv
// Controller for the radix-16 Booth datapath: registers operands, sequences the
// datapath and holds the captured product behind a valid/ready output.
module mul_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH         = mul_pkg::WIDTH,
  parameter bit ZeroSkip      = 1'b1,
  parameter bit FpuMultiplier = mul_pkg::FpuMultiplier
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mul_ctrl_if.slave            bus,
  output logic                 busy_o,
  output logic [15:0]          op_count_o,
  output logic                 dp_start_o,
  output logic [WIDTH-1:0]     dp_multiplicand_o,
  output logic [WIDTH-1:0]     dp_multiplier_o,
  input  logic [2*WIDTH-1:0]   dp_product_i,
  input  logic [WIDTH-1:0]     dp_product_rounded_i
);

  logic in_ready;
  logic accept;
  logic zero_load;
  logic capture;
  logic out_valid;
  logic done;
  logic operand_zero;

  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] product_q;
  logic [WIDTH-1:0]   product_rnd_q;
  logic [15:0]        op_count_q;

  assign operand_zero = (bus.multiplicand_i == '0) || (bus.multiplier_i == '0);

  mul_ctrl_fsm #(
    .WIDTH    (WIDTH),
    .ZeroSkip (ZeroSkip)
  ) u_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (bus.in_valid_i),
    .out_ready    (bus.out_ready_i),
    .operand_zero (operand_zero),
    .in_ready     (in_ready),
    .accept       (accept),
    .zero_load    (zero_load),
    .dp_start     (dp_start_o),
    .capture      (capture),
    .out_valid    (out_valid),
    .done         (done),
    .busy         (busy_o)
  );

  // Operands only change on acceptance, so they stay frozen from LOAD through CAPTURE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (accept) begin
      mcand_q  <= bus.multiplicand_i;
      mplier_q <= bus.multiplier_i;
    end
  end

  // Only one of the two result paths is live; the other is held at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_q     <= '0;
      product_rnd_q <= '0;
    end else if (zero_load) begin
      product_q     <= '0;
      product_rnd_q <= '0;
    end else if (capture) begin
      if (FpuMultiplier) begin
        product_q     <= '0;
        product_rnd_q <= dp_product_rounded_i;
      end else begin
        product_q     <= dp_product_i;
        product_rnd_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else if (done) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign dp_multiplicand_o     = mcand_q;
  assign dp_multiplier_o       = mplier_q;
  assign op_count_o            = op_count_q;
  assign bus.in_ready_o        = in_ready;
  assign bus.out_valid_o       = out_valid;
  assign bus.product_o         = product_q;
  assign bus.product_rounded_o = product_rnd_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// Scoreboard bench for mul_ctrl: a full-product and a rounded-product instance
// run the same directed operand pairs against a stub Booth datapath.
module tb_mul_ctrl;
  import mul_pkg::*;

  localparam int W = 32;
  localparam int ITERS = W / 4;

  typedef struct {
    logic [2*W-1:0] prod;
    logic [W-1:0]   rnd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int accept_cyc = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  logic         in_valid, out_ready;
  logic [W-1:0] mcand, mplier;

  mul_ctrl_if #(.WIDTH(W)) bus0 ();
  mul_ctrl_if #(.WIDTH(W)) bus1 ();

  assign bus0.in_valid_i     = in_valid;
  assign bus0.multiplicand_i = mcand;
  assign bus0.multiplier_i   = mplier;
  assign bus0.out_ready_i    = out_ready;
  assign bus1.in_valid_i     = in_valid;
  assign bus1.multiplicand_i = mcand;
  assign bus1.multiplier_i   = mplier;
  assign bus1.out_ready_i    = out_ready;

  logic           busy0, busy1, dp_start0, dp_start1;
  logic [15:0]    op_count0, op_count1;
  logic [W-1:0]   dp_a0, dp_b0, dp_a1, dp_b1;
  logic [2*W-1:0] dp_prod;
  logic [W-1:0]   dp_rnd;
  int             dp_cnt;

  mul_ctrl #(.WIDTH(W), .ZeroSkip(1'b1), .FpuMultiplier(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .busy_o(busy0), .op_count_o(op_count0),
    .dp_start_o(dp_start0), .dp_multiplicand_o(dp_a0), .dp_multiplier_o(dp_b0),
    .dp_product_i(dp_prod), .dp_product_rounded_i(dp_rnd)
  );

  mul_ctrl #(.WIDTH(W), .ZeroSkip(1'b1), .FpuMultiplier(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .busy_o(busy1), .op_count_o(op_count1),
    .dp_start_o(dp_start1), .dp_multiplicand_o(dp_a1), .dp_multiplier_o(dp_b1),
    .dp_product_i(dp_prod), .dp_product_rounded_i(dp_rnd)
  );

  // Datapath stub: shows a true result only during the CAPTURE cycle, junk otherwise.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_cnt  <= 0;
      dp_prod <= 64'hDEAD_BEEF_DEAD_BEEF;
      dp_rnd  <= 32'hDEAD_BEEF;
    end else if (dp_start0) begin
      dp_cnt  <= ITERS;
      dp_prod <= 64'hDEAD_BEEF_DEAD_BEEF;
      dp_rnd  <= 32'hDEAD_BEEF;
    end else if (dp_cnt == 1) begin
      dp_cnt  <= 0;
      dp_prod <= $signed({{W{dp_a0[W-1]}}, dp_a0}) * $signed({{W{dp_b0[W-1]}}, dp_b0});
      dp_rnd  <= dp_a0 * dp_b0 ^ 32'hC0DE_0000;
    end else if (dp_cnt > 0) begin
      dp_cnt <= dp_cnt - 1;
    end else begin
      dp_prod <= 64'hDEAD_BEEF_DEAD_BEEF;
      dp_rnd  <= 32'hDEAD_BEEF;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus0.out_valid_o === 1'b1 && bus0.out_ready_i === 1'b1) begin
      checkOutput("sb0 pending", 64'(q0.size() != 0), 64'd1);
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        checkOutput("sb0 product", bus0.product_o, e0.prod);
        checkOutput("sb0 rounded", 64'(bus0.product_rounded_o), 64'(e0.rnd));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus1.out_valid_o === 1'b1 && bus1.out_ready_i === 1'b1) begin
      checkOutput("sb1 pending", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        checkOutput("sb1 product", bus1.product_o, e1.prod);
        checkOutput("sb1 rounded", 64'(bus1.product_rounded_o), 64'(e1.rnd));
      end
    end
  end

  task automatic pushExpect(input logic [2*W-1:0] prod, input logic [W-1:0] rnd);
    exp_t a, b;
    a.prod = prod;  a.rnd = '0;
    b.prod = '0;    b.rnd = rnd;
    q0.push_back(a);
    q1.push_back(b);
  endtask

  task automatic waitAccept(input string name, input logic [2*W-1:0] prod, input logic [W-1:0] rnd);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus0.in_ready_o === 1'b1) break;
    end
    checkOutput({name, " in_ready"}, 64'(bus0.in_ready_o), 64'd1);
    accept_cyc = cyc;
    pushExpect(prod, rnd);
  endtask

  task automatic traceOp(input string name, input int exp_start_rel, input int exp_valid_rel);
    int starts = 0;
    int start_rel = -1;
    int valid_rel = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dp_start0 === 1'b1) begin
        starts++;
        if (start_rel < 0) start_rel = cyc - accept_cyc;
      end
      if (bus0.out_valid_o === 1'b1) begin
        valid_rel = cyc - accept_cyc;
        break;
      end
    end
    checkOutput({name, " start count"}, 64'(starts), (exp_start_rel < 0) ? 64'd0 : 64'd1);
    checkOutput({name, " start cycle"}, 64'(start_rel), 64'(exp_start_rel));
    checkOutput({name, " valid cycle"}, 64'(valid_rel), 64'(exp_valid_rel));
  endtask

  task automatic applyStimulus(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2*W-1:0] prod, input logic [W-1:0] rnd,
                               input int exp_start_rel, input int exp_valid_rel);
    @(posedge clk);
    #1;
    mcand    = a;
    mplier   = b;
    in_valid = 1'b1;
    waitAccept(name, prod, rnd);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    traceOp(name, exp_start_rel, exp_valid_rel);
  endtask

  task automatic checkCount(input string name, input logic [15:0] exp);
    @(posedge clk);
    #1;
    checkOutput({name, " op_count0"}, 64'(op_count0), 64'(exp));
    checkOutput({name, " op_count1"}, 64'(op_count1), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    mcand     = '0;
    mplier    = '0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("reset in_ready", 64'(bus0.in_ready_o), 64'd1);
    checkOutput("reset out_valid", 64'(bus0.out_valid_o), 64'd0);
    checkOutput("reset busy", 64'(busy0), 64'd0);
    checkOutput("reset op_count", 64'(op_count0), 64'd0);
    checkOutput("reset product", bus0.product_o, 64'd0);
    checkOutput("reset dp_start", 64'(dp_start0), 64'd0);
    checkOutput("reset rounded", 64'(bus1.product_rounded_o), 64'd0);

    @(posedge clk);
    #1 rst_n = 1'b1;

    applyStimulus("3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 32'hC0DE_000F, 1, 11);
    checkCount("3x5", 16'd1);
    applyStimulus("m1x1", 32'hFFFF_FFFF, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32'h3F21_FFFF, 1, 11);
    checkCount("m1x1", 16'd2);
    applyStimulus("minxmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 32'hC0DE_0000, 1, 11);
    checkCount("minxmin", 16'd3);
    applyStimulus("0x1234", 32'd0, 32'h1234, 64'd0, 32'd0, -1, 1);
    checkCount("0x1234", 16'd4);

    // Hold the result back while a new pair waits at the input.
    @(posedge clk);
    #1 out_ready = 1'b0;
    applyStimulus("5x5", 32'd5, 32'd5, 64'd25, 32'hC0DE_0019, 1, 11);
    @(posedge clk);
    #1;
    mcand    = 32'd7;
    mplier   = 32'd9;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp product", bus0.product_o, 64'd25);
      checkOutput("bp rounded", 64'(bus1.product_rounded_o), 64'h0000_0000_C0DE_0019);
      checkOutput("bp in_ready", 64'(bus0.in_ready_o), 64'd0);
      checkOutput("bp out_valid", 64'(bus0.out_valid_o), 64'd1);
      checkOutput("bp dp_start", 64'(dp_start0), 64'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    checkOutput("b2b in_ready", 64'(bus0.in_ready_o), 64'd1);
    accept_cyc = cyc;
    pushExpect(64'd63, 32'hC0DE_003F);
    @(posedge clk);
    #1 in_valid = 1'b0;
    traceOp("7x9", 1, 11);
    checkCount("7x9", 16'd6);

    // Abort an operation in the middle of RUN.
    @(posedge clk);
    #1;
    mcand    = 32'd2;
    mplier   = 32'd3;
    in_valid = 1'b1;
    waitAccept("2x3", 64'd6, 32'hC0DE_0006);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("mid-run busy", 64'(busy0), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort out_valid", 64'(bus0.out_valid_o), 64'd0);
    checkOutput("abort busy", 64'(busy0), 64'd0);
    checkOutput("abort op_count", 64'(op_count0), 64'd0);
    checkOutput("abort in_ready", 64'(bus0.in_ready_o), 64'd1);
    checkOutput("abort dp_start", 64'(dp_start0), 64'd0);
    checkOutput("abort dp operand", 64'(dp_a0), 64'd0);
    checkOutput("abort product", bus0.product_o, 64'd0);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;

    applyStimulus("2x2", 32'd2, 32'd2, 64'd4, 32'hC0DE_0004, 1, 11);
    checkCount("2x2", 16'd1);

    repeat (3) @(negedge clk);
    checkOutput("sb0 drained", 64'(q0.size()), 64'd0);
    checkOutput("sb1 drained", 64'(q1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
